// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner.
//   - Button index constants (bit order of btn_raw and the output vectors).
//   - Debounce FSM state encoding, also driven out of each cell for debug.
//   - Default debounce length: 10 ms at 100 MHz.
package btn_pkg;

    localparam int BTN_L = 0;
    localparam int BTN_U = 1;
    localparam int BTN_R = 2;
    localparam int BTN_D = 3;
    localparam int BTN_C = 4;

    localparam int DEBOUNCE_CYCLES_100MHZ = 1_000_000;

    typedef enum logic [1:0] {
        UP        = 2'd0,
        SETTLE_DN = 2'd1,
        DOWN      = 2'd2,
        SETTLE_UP = 2'd3
    } deb_state_t;

endpackage

// File: rtl/debounce_cell.sv
// One-bit button conditioner: 2-FF synchroniser followed by a debounce FSM.
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   btn_raw_i      asynchronous raw pin, 1 = pressed
//   level_o        debounced level
//   press_o        one-cycle strobe on a debounced 0->1 transition
//   release_o      one-cycle strobe on a debounced 1->0 transition
//   hold_o         level has been 1 for 2*DEBOUNCE_CYCLES since the press
//   state_o        current FSM state (debug)
// press_o/release_o are fire-and-forget strobes: there is no ready/valid
// handshake and no backpressure, so a consumer must sample them every cycle.
module debounce_cell
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100MHZ,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_raw_i,
    output logic       level_o,
    output logic       press_o,
    output logic       release_o,
    output logic       hold_o,
    output deb_state_t state_o
);

    // The DOWN state counts to 2*DEBOUNCE_CYCLES, which needs one bit more
    // than the settle counter alone.
    localparam int HW = CNT_W + 1;
    localparam logic [HW-1:0] DEB_MAX  = HW'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(2 * DEBOUNCE_CYCLES);

    logic            sync0_q;
    logic            sync1_q;
    deb_state_t      state_q;
    logic [HW-1:0]   cnt_q;
    logic [HW-1:0]   cnt_d;
    logic            level_q;
    logic            press_q;
    logic            release_q;
    logic            hold_q;

    assign cnt_d = cnt_q + HW'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync0_q   <= 1'b0;
            sync1_q   <= 1'b0;
            state_q   <= UP;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            sync0_q   <= btn_raw_i;
            sync1_q   <= sync0_q;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                UP: begin
                    if (sync1_q) begin
                        state_q <= SETTLE_DN;
                        cnt_q   <= HW'(1);
                    end
                end
                SETTLE_DN: begin
                    if (!sync1_q) begin
                        state_q <= UP;
                        cnt_q   <= '0;
                    end else if (cnt_d == DEB_MAX) begin
                        state_q <= DOWN;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DOWN: begin
                    if (!sync1_q) begin
                        state_q <= SETTLE_UP;
                        cnt_q   <= HW'(1);
                    end else if (cnt_q != HOLD_MAX) begin
                        // Saturating count; hold asserts on the edge it saturates.
                        cnt_q <= cnt_d;
                        if (cnt_d == HOLD_MAX) begin
                            hold_q <= 1'b1;
                        end
                    end
                end
                SETTLE_UP: begin
                    // Level and hold are kept while the release is unconfirmed.
                    if (sync1_q) begin
                        state_q <= DOWN;
                        cnt_q   <= '0;
                        hold_q  <= 1'b0;
                    end else if (cnt_d == DEB_MAX) begin
                        state_q   <= UP;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                        hold_q    <= 1'b0;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= UP;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign hold_o    = hold_q;
    assign state_o   = state_q;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front end: synchronises and debounces N_BTN raw pins
// independently, one debounce_cell per button.
// Ports:
//   CLK100MHZ, rst   clock and synchronous active-high reset
//   btn_raw          raw asynchronous pins (0=L,1=U,2=R,3=D,4=C), 1 = pressed
//   btn_level        debounced levels
//   btn_press        one-cycle press strobes
//   btn_release      one-cycle release strobes
//   btn_hold         long-hold flags
//   btn_state_dbg    per-button FSM state, 2 bits per button (debug)
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100MHZ,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic               CLK100MHZ,
    input  logic               rst,
    input  logic [N_BTN-1:0]   btn_raw,
    output logic [N_BTN-1:0]   btn_level,
    output logic [N_BTN-1:0]   btn_press,
    output logic [N_BTN-1:0]   btn_release,
    output logic [N_BTN-1:0]   btn_hold,
    output logic [2*N_BTN-1:0] btn_state_dbg
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_cell (
            .clk_i     (CLK100MHZ),
            .rst_i     (rst),
            .btn_raw_i (btn_raw[i]),
            .level_o   (btn_level[i]),
            .press_o   (btn_press[i]),
            .release_o (btn_release[i]),
            .hold_o    (btn_hold[i]),
            .state_o   (btn_state_dbg[2*i +: 2])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;
  import btn_pkg::*;

  localparam int N = 5;
  localparam int DEB = 4;
  localparam int EW = 16 + 4 * N;

  localparam logic [N-1:0] M_L = 5'(1) << BTN_L;
  localparam logic [N-1:0] M_U = 5'(1) << BTN_U;
  localparam logic [N-1:0] M_R = 5'(1) << BTN_R;
  localparam logic [N-1:0] M_D = 5'(1) << BTN_D;
  localparam logic [N-1:0] M_C = 5'(1) << BTN_C;
  localparam logic [N-1:0] Z = '0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_hold;
  logic [2*N-1:0] btn_state_dbg;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  btn_conditioner #(
    .N_BTN(N),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .CLK100MHZ(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_hold(btn_hold),
    .btn_state_dbg(btn_state_dbg)
  );

  // ---------------- scoreboard ----------------
  // Event word: {cycle, press, release, level, hold}
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;
  logic [N-1:0] prev_level = '0;
  logic [N-1:0] prev_hold = '0;

  function automatic logic [EW-1:0] ev(int c, logic [N-1:0] p, logic [N-1:0] r,
                                       logic [N-1:0] l, logic [N-1:0] h);
    return {16'(c), p, r, l, h};
  endfunction

  always @(negedge clk) begin
    logic [EW-1:0] obs;
    logic [EW-1:0] exp_v;
    if (mon_en) begin
      if ((|btn_press) || (|btn_release) || (btn_level != prev_level) || (btn_hold != prev_hold)) begin
        obs = {16'(cyc), btn_press, btn_release, btn_level, btn_hold};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got %h (cyc %0d) required none", obs, cyc);
        end else begin
          exp_v = exp_q.pop_front();
          if (obs !== exp_v) begin
            errors++;
            $display("FAIL event_cmp: got %h required %h (cyc %0d)", obs, exp_v, cyc);
          end
        end
      end
      prev_level = btn_level;
      prev_hold = btn_hold;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic set_bit(input int c, input int b, input logic v);
    wait_cyc(c);
    btn_raw[b] = v;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    btn_raw = '0;

    wait_cyc(1);
    check("reset_outputs", 32'({btn_level, btn_press, btn_release, btn_hold}), 32'd0);
    check("reset_state", 32'(btn_state_dbg), 32'd0);
    wait_cyc(2);
    rst = 1'b0;
    mon_en = 1'b1;

    // Clean press/release on L
    exp_q.push_back(ev(16, M_L, Z, M_L, Z));
    exp_q.push_back(ev(24, Z, Z, M_L, M_L));
    exp_q.push_back(ev(46, Z, M_L, Z, Z));
    set_bit(10, BTN_L, 1'b1);
    set_bit(40, BTN_L, 1'b0);

    // Bounce rejection on C: 1,0,1,0 for 2 cycles each then stays 1
    exp_q.push_back(ev(74, M_C, Z, M_C, Z));
    exp_q.push_back(ev(82, Z, Z, M_C, M_C));
    exp_q.push_back(ev(96, Z, M_C, Z, Z));
    set_bit(60, BTN_C, 1'b1);
    set_bit(62, BTN_C, 1'b0);
    set_bit(64, BTN_C, 1'b1);
    set_bit(66, BTN_C, 1'b0);
    set_bit(68, BTN_C, 1'b1);
    set_bit(90, BTN_C, 1'b0);

    // Hold on R for 30 cycles
    exp_q.push_back(ev(116, M_R, Z, M_R, Z));
    exp_q.push_back(ev(124, Z, Z, M_R, M_R));
    exp_q.push_back(ev(146, Z, M_R, Z, Z));
    set_bit(110, BTN_R, 1'b1);
    set_bit(140, BTN_R, 1'b0);

    // Simultaneous U and D
    exp_q.push_back(ev(166, M_U | M_D, Z, M_U | M_D, Z));
    exp_q.push_back(ev(174, Z, Z, M_U | M_D, M_U | M_D));
    exp_q.push_back(ev(186, Z, M_U, M_D, M_D));
    exp_q.push_back(ev(190, Z, M_D, Z, Z));
    wait_cyc(160);
    btn_raw[BTN_U] = 1'b1;
    btn_raw[BTN_D] = 1'b1;
    set_bit(180, BTN_U, 1'b0);
    set_bit(184, BTN_D, 1'b0);

    // Reset while L is down; L stays pressed through reset
    exp_q.push_back(ev(206, M_L, Z, M_L, Z));
    exp_q.push_back(ev(210, Z, Z, Z, Z));
    exp_q.push_back(ev(216, M_L, Z, M_L, Z));
    exp_q.push_back(ev(224, Z, Z, M_L, M_L));
    set_bit(200, BTN_L, 1'b1);
    wait_cyc(209);
    rst = 1'b1;
    wait_cyc(210);
    rst = 1'b0;

    // Short 3-cycle dip on L while held
    exp_q.push_back(ev(236, Z, Z, M_L, Z));
    exp_q.push_back(ev(244, Z, Z, M_L, M_L));
    exp_q.push_back(ev(256, Z, M_L, Z, Z));
    set_bit(230, BTN_L, 1'b0);
    set_bit(233, BTN_L, 1'b1);
    wait_cyc(234);
    check("dip_state_settle_up", 32'(btn_state_dbg[2*BTN_L +: 2]), 32'(SETTLE_UP));
    check("dip_level_kept", 32'(btn_level[BTN_L]), 32'd1);
    set_bit(250, BTN_L, 1'b0);

    // Boundary: 3-cycle glitch rejected, 4-cycle pulse accepted on R
    exp_q.push_back(ev(286, M_R, Z, M_R, Z));
    exp_q.push_back(ev(290, Z, M_R, Z, Z));
    set_bit(270, BTN_R, 1'b1);
    set_bit(273, BTN_R, 1'b0);
    wait_cyc(278);
    check("glitch_state_up", 32'(btn_state_dbg[2*BTN_R +: 2]), 32'(UP));
    set_bit(280, BTN_R, 1'b1);
    set_bit(284, BTN_R, 1'b0);

    // ---------------- final report ----------------
    wait_cyc(310);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Front-end conditioner for the board push-buttons. It synchronises the raw asynchronous button inputs to `CLK100MHZ` and debounces each one independently. For every button it produces a clean level plus single-cycle press and release pulses. It sits between the top-level pins and the calculator logic, which consumes the release pulses as operation triggers.

## Interface
- `N_BTN`, default 5: number of buttons. Bit order is 0=L, 1=U, 2=R, 3=D, 4=C.
- `DEBOUNCE_CYCLES`, default 1_000_000: required stable cycles, i.e. 10 ms at 100 MHz. Legal range is ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: counter width, derived; do not override.
- `CLK100MHZ`  in  1: the single clock.
- `rst`  in  1: synchronous, active-high reset.
- `btn_raw`  in  N_BTN: raw button pins, asynchronous, 1 = pressed.
- `btn_level`  out  N_BTN: debounced level, 1 = pressed.
- `btn_press`  out  N_BTN: one-cycle pulse when a debounced 0→1 transition occurs.
- `btn_release`  out  N_BTN: one-cycle pulse when a debounced 1→0 transition occurs.
- `btn_hold`  out  N_BTN: high while the level has been 1 for ≥ 2·DEBOUNCE_CYCLES since the press.

## Operation
- Each bit passes through a 2-FF synchroniser (`sync0`, `sync1`). All further logic uses `sync1` only.
- Each button has its own FSM and counter:
  - **UP**: level 0. If `sync1`=1, go to SETTLE_DN with cnt=1.
  - **SETTLE_DN**: if `sync1`=0, return to UP with cnt=0. Otherwise cnt+1. When cnt reaches DEBOUNCE_CYCLES, go to DOWN, set level=1, pulse press, and clear cnt.
  - **DOWN**: level 1. cnt counts up and saturates at 2·DEBOUNCE_CYCLES; at saturation, hold=1. If `sync1`=0, go to SETTLE_UP with cnt=1.
  - **SETTLE_UP**: level stays 1 and hold stays as it was. If `sync1`=1, return to DOWN; cnt restarts at 0 and hold clears. Otherwise cnt+1. When cnt reaches DEBOUNCE_CYCLES, go to UP, set level=0, pulse release, and clear hold and cnt.
- A glitch shorter than DEBOUNCE_CYCLES consecutive cycles never changes the level and never pulses.
- Buttons are fully independent. Simultaneous events on several bits produce simultaneous pulses, with no arbitration.
- The counter never wraps. Every comparison is an equality test against the constant, and the DOWN counter saturates.
- A button held through reset deassertion is treated as a new press. It yields `btn_press` after the normal latency.
- Reset asserted mid-operation: all state is abandoned the next cycle. No release pulse is emitted for a button that was down.

## Timing
- Reset values (all outputs and internal registers): `btn_level`=0, `btn_press`=0, `btn_release`=0, `btn_hold`=0, sync FFs 0, state UP, cnt 0.
- Press latency: pin edge (stable thereafter) → `btn_press` high = 2 + DEBOUNCE_CYCLES cycles. `btn_level` rises on the same edge as `btn_press`.
- Release latency: symmetric with press latency. `btn_level` falls on the same edge as `btn_release`.
- `btn_press` and `btn_release` are registered, exactly 1 cycle wide, and never high together on the same bit.
- `btn_hold` rises 2·DEBOUNCE_CYCLES cycles after `btn_press`.
- `btn_hold` falls with `btn_release`, or on a return from SETTLE_UP to DOWN.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Package `btn_pkg` contains:
  - button index constants `BTN_L`=0, `BTN_U`=1, `BTN_R`=2, `BTN_D`=3, `BTN_C`=4;
  - state enum `deb_state_t` {UP, SETTLE_DN, DOWN, SETTLE_UP};
  - default `DEBOUNCE_CYCLES_100MHZ`.
- Sub-module `debounce_cell` implements one bit (synchroniser, FSM, counter, outputs). The top level instantiates it N_BTN times in a generate loop, with no extra logic.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- **Clean press/release**: `btn_raw[0]` rises at cycle 10 and falls at cycle 40 → `btn_press[0]` is a 1-cycle pulse at cycle 16 and `btn_release[0]` at cycle 46. `btn_level[0]` is high over cycles 16–45.
- **Bounce rejection**: `btn_raw[4]` toggles 1,0,1,0 each for 2 cycles, then stays 1 → exactly one `btn_press[4]` pulse, 6 cycles after the final rise. No `btn_release[4]`.
- **Hold**: `btn_raw[2]` is held for 30 cycles → `btn_hold[2]` rises 8 cycles after `btn_press[2]` and falls with `btn_release[2]`.
- **Simultaneous buttons**: bits 1 and 3 rise on the same cycle → `btn_press[1]` and `btn_press[3]` pulse on the same cycle. All other bits stay 0.
- **Reset mid-press**: bit 0 is in DOWN and `rst` is high for 1 cycle → all outputs are 0 on the next cycle and no release pulse occurs. With the raw input still 1, a new `btn_press[0]` follows 6 cycles after reset deassertion.
- **Short dip while held**: `btn_raw[0]` drops for 3 cycles while in DOWN → no release and `btn_level` stays 1. `btn_hold` clears and re-arms 8 cycles later.
